// File: rtl/gf_pkg.sv
// GF(2^8) field parameters, shared types and the constant-free multiplier.
// Latency: none (types, constants and a combinational function only).
// Backpressure: not applicable.
package gf_pkg;

   localparam int SYMB_WIDTH = 8;
   localparam int ROOTS_NUM  = 4;
   localparam int T_LEN      = ROOTS_NUM / 2;
   localparam int CNT_W      = $clog2(T_LEN + 2);
   // L can grow to ROOTS_NUM internally before saturation on the output
   localparam int LEN_W      = $clog2(ROOTS_NUM + 2);
   localparam int R_W        = $clog2(ROOTS_NUM);

   // x^8 + x^4 + x^3 + x^2 + 1
   localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

   typedef logic [SYMB_WIDTH-1:0] symb_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } bm_state_t;

   // Shift-and-add multiply, reducing by the primitive polynomial each step
   function automatic symb_t gf_mult(input symb_t a, input symb_t b);
      symb_t acc;
      symb_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
      end
      return acc;
   endfunction

endpackage

// File: rtl/rs_bm_delta.sv
// Berlekamp-Massey discrepancy: delta = sum Lambda_i * S_(r-i).
// Latency: purely combinational.
// Backpressure: none; inputs are the registered solver state.
module rs_bm_delta
   import gf_pkg::*;
(
   input  logic [SYMB_WIDTH-1:0] lambda [T_LEN+1],
   input  logic [SYMB_WIDTH-1:0] synd   [ROOTS_NUM],
   input  logic [R_W-1:0]        r,
   output logic [SYMB_WIDTH-1:0] delta
);

   logic [R_W-1:0] idx;

   // Terms whose syndrome index would be negative contribute nothing
   always_comb begin
      delta = '0;
      idx   = '0;
      for (int i = 0; i <= T_LEN; i++) begin
         if (int'(r) >= i) begin
            idx   = r - R_W'(i);
            delta = delta ^ gf_mult(lambda[i], synd[idx]);
         end
      end
   end

endmodule

// File: rtl/rs_berlekamp.sv
// Inversionless Berlekamp-Massey solver: syndromes in, scaled Lambda(x), L and fail out.
// Latency: ROOTS_NUM+1 cycles from accepted syndrome_vld to the sigma_vld pulse.
// Backpressure: none; syndrome_vld while busy is discarded and flagged on drop next cycle.
module rs_berlekamp
   import gf_pkg::*;
(
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [SYMB_WIDTH-1:0] syndrome [ROOTS_NUM],
   input  logic                  syndrome_vld,
   output logic [SYMB_WIDTH-1:0] sigma    [T_LEN+1],
   output logic [CNT_W-1:0]      err_cnt,
   output logic                  fail,
   output logic                  sigma_vld,
   output logic                  busy,
   output logic                  drop
);

   localparam int NL = T_LEN + 1;

   bm_state_t        state_q, state_d;
   symb_t            synd_q   [ROOTS_NUM];
   symb_t            synd_d   [ROOTS_NUM];
   symb_t            lambda_q [NL];
   symb_t            lambda_d [NL];
   symb_t            b_q      [NL];
   symb_t            b_d      [NL];
   symb_t            gamma_q, gamma_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [R_W-1:0]   r_q, r_d;
   symb_t            sigma_q  [NL];
   symb_t            sigma_d  [NL];
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             fail_q, fail_d;
   logic             sigma_vld_q, sigma_vld_d;
   logic             busy_q, busy_d;
   logic             drop_q, drop_d;

   symb_t            delta;
   symb_t            lambda_upd [NL];
   logic             do_swap;
   logic [LEN_W-1:0] len_nxt;

   rs_bm_delta u_delta (
      .lambda (lambda_q),
      .synd   (synd_q),
      .r      (r_q),
      .delta  (delta)
   );

   // One iteration: Lambda' = gamma*Lambda + delta*x*B, and the length-change decision
   always_comb begin
      do_swap       = (delta != '0) && ((2 * int'(len_q)) <= int'(r_q));
      len_nxt       = do_swap ? LEN_W'(int'(r_q) + 1 - int'(len_q)) : len_q;
      lambda_upd[0] = gf_mult(gamma_q, lambda_q[0]);
      for (int i = 1; i < NL; i++) begin
         lambda_upd[i] = gf_mult(gamma_q, lambda_q[i]) ^ gf_mult(delta, b_q[i-1]);
      end
   end

   // Next-state: results are registered on the last CALC step so they are visible during DONE
   always_comb begin
      state_d     = state_q;
      synd_d      = synd_q;
      lambda_d    = lambda_q;
      b_d         = b_q;
      gamma_d     = gamma_q;
      len_d       = len_q;
      r_d         = r_q;
      sigma_d     = sigma_q;
      err_cnt_d   = err_cnt_q;
      fail_d      = fail_q;
      sigma_vld_d = 1'b0;
      busy_d      = busy_q;
      drop_d      = syndrome_vld && (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (syndrome_vld) begin
               state_d = ST_CALC;
               synd_d  = syndrome;
               for (int i = 0; i < NL; i++) begin
                  lambda_d[i] = '0;
                  b_d[i]      = '0;
               end
               lambda_d[0] = symb_t'(1);
               b_d[0]      = symb_t'(1);
               gamma_d     = symb_t'(1);
               len_d       = '0;
               r_d         = '0;
               busy_d      = 1'b1;
            end
         end
         ST_CALC: begin
            lambda_d = lambda_upd;
            len_d    = len_nxt;
            if (do_swap) begin
               b_d     = lambda_q;
               gamma_d = delta;
            end else begin
               b_d[0] = '0;
               for (int i = 1; i < NL; i++) b_d[i] = b_q[i-1];
            end
            if (int'(r_q) == ROOTS_NUM - 1) begin
               state_d     = ST_DONE;
               sigma_d     = lambda_upd;
               fail_d      = int'(len_nxt) > T_LEN;
               err_cnt_d   = (int'(len_nxt) > T_LEN) ? CNT_W'(T_LEN + 1) : CNT_W'(len_nxt);
               sigma_vld_d = 1'b1;
            end else begin
               r_d = r_q + R_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // All state and outputs; reset aborts any codeword in flight
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         synd_q      <= '{default: '0};
         lambda_q    <= '{default: '0};
         b_q         <= '{default: '0};
         gamma_q     <= '0;
         len_q       <= '0;
         r_q         <= '0;
         sigma_q     <= '{default: '0};
         err_cnt_q   <= '0;
         fail_q      <= 1'b0;
         sigma_vld_q <= 1'b0;
         busy_q      <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         synd_q      <= synd_d;
         lambda_q    <= lambda_d;
         b_q         <= b_d;
         gamma_q     <= gamma_d;
         len_q       <= len_d;
         r_q         <= r_d;
         sigma_q     <= sigma_d;
         err_cnt_q   <= err_cnt_d;
         fail_q      <= fail_d;
         sigma_vld_q <= sigma_vld_d;
         busy_q      <= busy_d;
         drop_q      <= drop_d;
      end
   end

   assign sigma     = sigma_q;
   assign err_cnt   = err_cnt_q;
   assign fail      = fail_q;
   assign sigma_vld = sigma_vld_q;
   assign busy      = busy_q;
   assign drop      = drop_q;

endmodule
